// File: rtl/cbus_seq_if.sv
// Chip-bus sequencer signal bundle: two requester ports plus the shared bd bus pins.
interface cbus_seq_if;
  logic       req0, req1;
  logic       sel0, sel1;
  logic       we0, we1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       busy;
  logic [7:0] bd_in;
  logic [7:0] bd_out;
  logic       bd_oe;
  logic       brd_n, bwr_n;
  logic       w5300_cs_n, sl811_cs_n;
  logic [9:0] w5300_addr;
  logic       sl811_a0;

  modport slave (
    input  req0, req1, sel0, sel1, we0, we1, addr0, addr1, wdata0, wdata1, bd_in,
    output ack0, ack1, rdata, busy, bd_out, bd_oe, brd_n, bwr_n,
           w5300_cs_n, sl811_cs_n, w5300_addr, sl811_a0
  );

  modport master (
    output req0, req1, sel0, sel1, we0, we1, addr0, addr1, wdata0, wdata1, bd_in,
    input  ack0, ack1, rdata, busy, bd_out, bd_oe, brd_n, bwr_n,
           w5300_cs_n, sl811_cs_n, w5300_addr, sl811_a0
  );
endinterface

// File: rtl/cbus_seq.sv
// Round-robin arbiter and timed cycle sequencer for the W5300/SL811 shared bd bus.
// Every output is a register updated together with the state transition.
module cbus_seq #(
  parameter int W_SETUP  = 2,
  parameter int W_STROBE = 4,
  parameter int S_SETUP  = 1,
  parameter int S_STROBE = 6
) (
  input  logic       fclk,
  input  logic       rst,
  cbus_seq_if.slave  bus
);

  if (W_SETUP < 1 || W_SETUP > 15 || W_STROBE < 1 || W_STROBE > 15 ||
      S_SETUP < 1 || S_SETUP > 15 || S_STROBE < 1 || S_STROBE > 15) begin : g_bad_param
    $error("cbus_seq: timing parameters must be in 1..15");
  end

  localparam logic [3:0] W_SET_LD = 4'(W_SETUP - 1);
  localparam logic [3:0] W_STR_LD = 4'(W_STROBE - 1);
  localparam logic [3:0] S_SET_LD = 4'(S_SETUP - 1);
  localparam logic [3:0] S_STR_LD = 4'(S_STROBE - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       last_q, gnt_q, sel_q, we_q;
  logic       ack0_q, ack1_q, busy_q, bd_oe_q, brd_n_q, bwr_n_q;
  logic       w_cs_n_q, s_cs_n_q, a0_q;
  logic [7:0] rdata_q, bd_out_q;
  logic [9:0] waddr_q;

  // Tie goes to the port that did not win last time.
  logic       gnt_d;
  logic       sel_d, we_d;
  logic [9:0] addr_d;
  logic [7:0] wdata_d;

  always_comb begin
    gnt_d   = bus.req0 ? (bus.req1 & ~last_q) : 1'b1;
    sel_d   = gnt_d ? bus.sel1   : bus.sel0;
    we_d    = gnt_d ? bus.we1    : bus.we0;
    addr_d  = gnt_d ? bus.addr1  : bus.addr0;
    wdata_d = gnt_d ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      bd_oe_q  <= 1'b0;
      brd_n_q  <= 1'b1;
      bwr_n_q  <= 1'b1;
      w_cs_n_q <= 1'b1;
      s_cs_n_q <= 1'b1;
      a0_q     <= 1'b0;
      rdata_q  <= '0;
      bd_out_q <= '0;
      waddr_q  <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req0 || bus.req1) begin
          state_q <= SETUP;
          busy_q  <= 1'b1;
          last_q  <= gnt_d;
          gnt_q   <= gnt_d;
          sel_q   <= sel_d;
          we_q    <= we_d;
          cnt_q   <= sel_d ? S_SET_LD : W_SET_LD;
          // The idle chip keeps its address pins where they were.
          if (sel_d) begin
            s_cs_n_q <= 1'b0;
            a0_q     <= addr_d[0];
          end else begin
            w_cs_n_q <= 1'b0;
            waddr_q  <= addr_d;
          end
          if (we_d) begin
            bd_out_q <= wdata_d;
            bd_oe_q  <= 1'b1;
          end
        end
        SETUP: if (cnt_q == '0) begin
          state_q <= STROBE;
          cnt_q   <= sel_q ? S_STR_LD : W_STR_LD;
          if (we_q) bwr_n_q <= 1'b0;
          else      brd_n_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        STROBE: if (cnt_q == '0) begin
          state_q <= HOLD;
          brd_n_q <= 1'b1;
          bwr_n_q <= 1'b1;
          if (!we_q) rdata_q <= bus.bd_in;
          if (gnt_q) ack1_q <= 1'b1;
          else       ack0_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        HOLD: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          w_cs_n_q <= 1'b1;
          s_cs_n_q <= 1'b1;
          bd_oe_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.bd_out     = bd_out_q;
  assign bus.bd_oe      = bd_oe_q;
  assign bus.brd_n      = brd_n_q;
  assign bus.bwr_n      = bwr_n_q;
  assign bus.w5300_cs_n = w_cs_n_q;
  assign bus.sl811_cs_n = s_cs_n_q;
  assign bus.w5300_addr = waddr_q;
  assign bus.sl811_a0   = a0_q;

endmodule

// File: tb/tb_cbus_seq.sv
// Directed bench for cbus_seq: transaction-timeline model checked every cycle plus literal pins.
module tb_cbus_seq;
  localparam int WS = 2, WT = 4, SS = 1, ST = 6;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  cbus_seq_if bus();

  cbus_seq #(.W_SETUP(WS), .W_STROBE(WT), .S_SETUP(SS), .S_STROBE(ST)) dut (
    .fclk(fclk), .rst(rst), .bus(bus)
  );

  always #10 fclk = ~fclk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is a window of setup+strobe+1 cycles starting the cycle after grant.
  bit         chk_en = 0;
  int         mc = 0;
  bit         m_act = 0, m_last = 1, m_port = 0, m_sel = 0, m_we = 0, m_a0 = 0;
  int         m_start = 0, m_set = 0, m_str = 0;
  logic [7:0] m_rdata = 0, m_bdout = 0;
  logic [9:0] m_waddr = 0;

  // Literal-check monitors
  int cnt_wcs, cnt_scs, cnt_brd, cnt_bwr, cnt_oe, cnt_ack0, cnt_ack1;
  int first_cs, first_str;
  int ack_log[$];

  task automatic clr();
    cnt_wcs = 0; cnt_scs = 0; cnt_brd = 0; cnt_bwr = 0; cnt_oe = 0;
    cnt_ack0 = 0; cnt_ack1 = 0; first_cs = -1; first_str = -1;
    ack_log.delete();
  endtask

  always @(negedge fclk) begin
    int  off;
    bit  p;
    if (chk_en) begin
      off = mc - m_start;
      chk("w5300_cs_n", bus.w5300_cs_n, !(m_act && !m_sel));
      chk("sl811_cs_n", bus.sl811_cs_n, !(m_act && m_sel));
      chk("brd_n", bus.brd_n, !(m_act && !m_we && off >= m_set && off < m_set + m_str));
      chk("bwr_n", bus.bwr_n, !(m_act && m_we && off >= m_set && off < m_set + m_str));
      chk("ack0", bus.ack0, m_act && !m_port && off == m_set + m_str);
      chk("ack1", bus.ack1, m_act && m_port && off == m_set + m_str);
      chk("busy", bus.busy, m_act);
      chk("bd_oe", bus.bd_oe, m_act && m_we);
      chk("rdata", bus.rdata, m_rdata);
      chk("bd_out", bus.bd_out, m_bdout);
      chk("w5300_addr", bus.w5300_addr, m_waddr);
      chk("sl811_a0", bus.sl811_a0, m_a0);
    end
    // monitors
    if (!bus.w5300_cs_n) cnt_wcs++;
    if (!bus.sl811_cs_n) cnt_scs++;
    if (!bus.brd_n) cnt_brd++;
    if (!bus.bwr_n) cnt_bwr++;
    if (bus.bd_oe) cnt_oe++;
    if (bus.ack0) begin cnt_ack0++; ack_log.push_back(0); end
    if (bus.ack1) begin cnt_ack1++; ack_log.push_back(1); end
    if (first_cs < 0 && !(bus.w5300_cs_n && bus.sl811_cs_n)) first_cs = mc;
    if (first_str < 0 && !(bus.brd_n && bus.bwr_n)) first_str = mc;
    // advance the model to the next cycle using what the DUT samples at the coming edge
    if (rst) begin
      m_act = 0; m_last = 1; m_rdata = 0; m_bdout = 0; m_waddr = 0; m_a0 = 0;
      chk_en = 1;
    end else if (m_act) begin
      off = mc - m_start;
      if (off == m_set + m_str - 1 && !m_we) m_rdata = bus.bd_in;
      if (off == m_set + m_str) m_act = 0;
    end else if (bus.req0 || bus.req1) begin
      p = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      m_port = p; m_last = p; m_act = 1; m_start = mc + 1;
      m_sel = p ? bus.sel1 : bus.sel0;
      m_we  = p ? bus.we1  : bus.we0;
      m_set = m_sel ? SS : WS;
      m_str = m_sel ? ST : WT;
      if (m_sel) m_a0 = p ? bus.addr1[0] : bus.addr0[0];
      else       m_waddr = p ? bus.addr1 : bus.addr0;
      if (m_we)  m_bdout = p ? bus.wdata1 : bus.wdata0;
    end
    mc++;
  end

  task automatic drive(input int p, input logic r, input logic s, input logic w,
                       input logic [9:0] a, input logic [7:0] d);
    if (p == 0) begin bus.req0 = r; bus.sel0 = s; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = r; bus.sel1 = s; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
  endtask

  task automatic set_req(input int p, input logic r);
    if (p == 0) bus.req0 = r;
    else        bus.req1 = r;
  endtask

  // Waits (bounded) for this port's ack, then returns just after the edge that sampled it.
  task automatic wait_ack(input int p, input string nm);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge fclk);
      got = (p == 0) ? bus.ack0 : bus.ack1;
    end
    chk(nm, got, 1'b1);
    @(posedge fclk); #1;
  endtask

  task automatic issue(input int p, input logic s, input logic w, input logic [9:0] a,
                       input logic [7:0] d, input bit extra);
    drive(p, 1'b1, s, w, a, d);
    wait_ack(p, "ack_timeout");
    if (extra) begin
      @(posedge fclk); #1;
      set_req(p, 1'b0);
      wait_ack(p, "ack2_timeout");
    end else begin
      set_req(p, 1'b0);
    end
  endtask

  initial begin
    int exp3[8];
    int exp4[3];
    exp3 = '{0, 1, 0, 1, 0, 1, 0, 1};
    exp4 = '{0, 1, 0};
    drive(0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0);
    bus.bd_in = 8'h00;
    clr();
    repeat (3) @(posedge fclk);
    #1 rst = 1'b0;

    // reset state
    @(negedge fclk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_wcs", bus.w5300_cs_n, 1'b1);
    chk("rst_scs", bus.sl811_cs_n, 1'b1);
    chk("rst_strobes", {bus.brd_n, bus.bwr_n}, 2'b11);
    chk("rst_oe", bus.bd_oe, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_waddr", bus.w5300_addr, 10'h000);
    @(posedge fclk); #1;

    // single W5300 read on port 0
    bus.bd_in = 8'hA5;
    clr();
    issue(0, 1'b0, 1'b0, 10'h155, 8'h00, 1'b0);
    chk("t1_wcs_len", cnt_wcs, 7);
    chk("t1_brd_len", cnt_brd, 4);
    chk("t1_brd_offset", first_str - first_cs, 2);
    chk("t1_ack0", cnt_ack0, 1);
    chk("t1_rdata", bus.rdata, 8'hA5);
    chk("t1_scs", cnt_scs, 0);
    chk("t1_waddr", bus.w5300_addr, 10'h155);

    // SL811 write on port 1
    clr();
    issue(1, 1'b1, 1'b1, 10'h001, 8'h3C, 1'b0);
    chk("t2_a0", bus.sl811_a0, 1'b1);
    chk("t2_bwr_len", cnt_bwr, 6);
    chk("t2_oe_len", cnt_oe, 8);
    chk("t2_scs_len", cnt_scs, 8);
    chk("t2_bdout", bus.bd_out, 8'h3C);
    chk("t2_ack1", cnt_ack1, 1);
    chk("t2_wcs", cnt_wcs, 0);
    chk("t2_waddr_held", bus.w5300_addr, 10'h155);

    // both ports saturated after a reset: strict alternation, port 0 first
    rst = 1'b1;
    @(posedge fclk); #1 rst = 1'b0;
    clr();
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 1'b1, 10'(i + 16), 8'(i + 8'h40), 1'b0);
      for (int j = 0; j < 4; j++) issue(1, 1'b1, 1'b0, 10'(j), 8'h00, 1'b0);
    join
    chk("t3_nack", ack_log.size(), 8);
    for (int k = 0; k < 8 && k < ack_log.size(); k++) chk("t3_order", ack_log[k], exp3[k]);

    // port 0 held, port 1 arrives mid-cycle and is served next
    clr();
    fork
      begin
        issue(0, 1'b0, 1'b0, 10'h0AA, 8'h00, 1'b0);
        issue(0, 1'b0, 1'b0, 10'h0AB, 8'h00, 1'b0);
      end
      begin
        repeat (3) @(posedge fclk);
        #1 issue(1, 1'b1, 1'b1, 10'h002, 8'h77, 1'b0);
      end
    join
    chk("t4_nack", ack_log.size(), 3);
    for (int k = 0; k < 3 && k < ack_log.size(); k++) chk("t4_order", ack_log[k], exp4[k]);

    // reset in the second strobe cycle of a W5300 read
    clr();
    bus.bd_in = 8'h11;
    drive(0, 1'b1, 1'b0, 1'b0, 10'h3FF, 8'h00);
    repeat (4) @(posedge fclk);
    #1 rst = 1'b1;
    @(negedge fclk);
    chk("t5_in_strobe", bus.brd_n, 1'b0);
    @(posedge fclk); #1;
    rst = 1'b0;
    set_req(0, 1'b0);
    @(negedge fclk);
    chk("t5_strobes", {bus.brd_n, bus.bwr_n}, 2'b11);
    chk("t5_cs", {bus.w5300_cs_n, bus.sl811_cs_n}, 2'b11);
    chk("t5_oe", bus.bd_oe, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_noack", cnt_ack0 + cnt_ack1, 0);
    @(posedge fclk); #1;
    bus.bd_in = 8'hC3;
    issue(0, 1'b0, 1'b0, 10'h2AA, 8'h00, 1'b0);
    chk("t5_retry_ack", cnt_ack0, 1);
    chk("t5_retry_rdata", bus.rdata, 8'hC3);

    // req held one cycle past ack starts a second read
    clr();
    bus.bd_in = 8'h5A;
    issue(0, 1'b0, 1'b0, 10'h100, 8'h00, 1'b1);
    chk("t6_acks", cnt_ack0, 2);
    chk("t6_brd_len", cnt_brd, 8);
    chk("t6_rdata", bus.rdata, 8'h5A);

    repeat (3) @(posedge fclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
